// File: rtl/clk_tick_divider.sv
// -----------------------------------------------------------------------------
// clk_tick_divider
//
// Multi-channel programmable clock divider / baud-tick generator. Each channel
// divides clk by a runtime-programmable integer D. It produces two outputs:
//   - tick : a one-cycle strobe once per D cycles, meant to be used as a clock
//            enable.
//   - tclk : a 50%-duty toggle with a period of 2*D.
//
// Parameters
//   NUM_CH      : number of independent channels (1..16)
//   CNT_W       : width of each counter and divisor register
//   DEFAULT_DIV : divisor loaded into every channel at reset
//   SEL_W       : derived channel-select width, max(1, clog2(NUM_CH))
//
// Ports
//   clk      in  system clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   en       in  [NUM_CH]  per-channel run enable
//   div_wr   in  divisor write strobe (one cycle)
//   div_sel  in  [SEL_W]   channel index for the write (>= NUM_CH ignored)
//   div_data in  [CNT_W]   new divisor value (0 stalls the channel)
//   sync     in  phase-align all channels (only with CLKDIV_PHASE_SYNC_EN)
//   tick     out [NUM_CH]  registered one-cycle strobe per channel period
//   tclk     out [NUM_CH]  registered toggle output, period 2*D
//
// Optional feature
//   CLKDIV_PHASE_SYNC_EN : when defined, adds the sync port. When sync is high
//   on an edge, every channel's counter and outputs clear, regardless of en.
//   A divisor write on the same edge still lands.
//
// Per-channel precedence on one edge:
//   reset > sync > divisor write > en=0 > normal count
// -----------------------------------------------------------------------------
module clk_tick_divider #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 325,
  localparam int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] tclk
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Per-channel state.
  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] tclk_q, tclk_d;

  // Phase-sync request. It is tied low when the feature is not built, so the
  // next-state logic below is the same in both builds.
  logic sync_w;
`ifdef CLKDIV_PHASE_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  // Write decode. The select is compared only against real channel indices,
  // so an out-of-range div_sel matches nothing and the write is dropped.
  logic [NUM_CH-1:0] wr_hit;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see
    // values already computed in this pass; state registers use '<=' only.
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = div_wr && (32'(div_sel) == i);
    end
  end

  // Next-state logic for all channels.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: every output of this block gets a default first. A path that
      // left one unassigned would infer a latch.
      div_d[i]  = div_q[i];
      cnt_d[i]  = cnt_q[i];
      tick_d[i] = 1'b0;
      tclk_d[i] = tclk_q[i];

      if (sync_w) begin
        // Global phase alignment. A write on the same edge still updates D.
        cnt_d[i]  = '0;
        tclk_d[i] = 1'b0;
        if (wr_hit[i]) begin
          div_d[i] = div_data;
        end
      end else if (wr_hit[i]) begin
        // The new divisor restarts the period. There is no tick on this edge,
        // even if the old count was terminal, and tclk holds.
        div_d[i] = div_data;
        cnt_d[i] = '0;
      end else if (!en[i] || (div_q[i] == '0)) begin
        // Disabled or stalled (D=0): the counter parks at 0 and tclk holds.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == (div_q[i] - ONE)) begin
        // Terminal count. With D=1 this happens every edge, so tick stays
        // high and tclk toggles every cycle.
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
        tclk_d[i] = ~tclk_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these per-channel arrays are a handful of control registers,
      // not a RAM, so each element is reset explicitly to a known value.
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= RST_DIV;
        cnt_q[i] <= '0;
      end
      tick_q <= '0;
      tclk_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      tick_q <= tick_d;
      tclk_q <= tclk_d;
    end
  end

  assign tick = tick_q;
  assign tclk = tclk_q;

endmodule

// File: tb/tb_clk_tick_divider.sv
// -----------------------------------------------------------------------------
// tb_clk_tick_divider
//
// Self-checking bench for clk_tick_divider (NUM_CH=4, CNT_W=16, DEFAULT_DIV=325).
//
// Each clock edge, a behavioural model pushes the expected {tick, tclk}. The
// value is popped and compared on the following falling edge. The model counts
// down the edges remaining to the next tick.
//
// Scenario tasks also check spec-level numbers directly: tick spacing,
// write/terminal behaviour, disable hold, async reset, and sync.
// -----------------------------------------------------------------------------
module tb_clk_tick_divider;

  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 16;
  localparam int DEFAULT_DIV = 325;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] en;
  logic              div_wr;
  logic [1:0]        div_sel;
  logic [CNT_W-1:0]  div_data;
  logic              sync;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] tclk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state.
  int                m_d    [NUM_CH];
  int                m_left [NUM_CH];
  logic [NUM_CH-1:0] m_tick;
  logic [NUM_CH-1:0] m_tclk;

  logic [2*NUM_CH-1:0] sb_q[$];

  clk_tick_divider #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_wr   (div_wr),
    .div_sel  (div_sel),
    .div_data (div_data),
`ifdef CLKDIV_PHASE_SYNC_EN
    .sync     (sync),
`endif
    .tick     (tick),
    .tclk     (tclk)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_d[i]    = DEFAULT_DIV;
      m_left[i] = DEFAULT_DIV;
    end
    m_tick = '0;
    m_tclk = '0;
  endtask

  // Advance one clock.
  // - Rising edge: update the model from the stable inputs and push the
  //   expected outputs.
  // - Falling edge: pop the expected outputs and compare them with the DUT.
  task automatic step();
    logic [2*NUM_CH-1:0] exp_v;
    bit hit;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        hit = div_wr && (int'(div_sel) == i);
        if (sync || hit) begin
          if (hit) m_d[i] = int'(div_data);
          m_left[i] = m_d[i];
          m_tick[i] = 1'b0;
          if (sync) m_tclk[i] = 1'b0;
        end else if (!en[i] || m_d[i] == 0) begin
          m_left[i] = m_d[i];
          m_tick[i] = 1'b0;
        end else if (m_left[i] == 1) begin
          m_left[i] = m_d[i];
          m_tick[i] = 1'b1;
          m_tclk[i] = ~m_tclk[i];
        end else begin
          m_left[i] = m_left[i] - 1;
          m_tick[i] = 1'b0;
        end
      end
    end
    sb_q.push_back({m_tick, m_tclk});
    @(negedge clk);
    exp_v = sb_q.pop_front();
    n_total++;
    if ({tick, tclk} !== exp_v) begin
      n_bad++;
      $display("FAIL scoreboard t=%0t tick/tclk got %b/%b want %b/%b",
               $time, tick, tclk, exp_v[2*NUM_CH-1:NUM_CH], exp_v[NUM_CH-1:0]);
    end
  endtask

  task automatic write_div(input int sel, input int data);
    div_wr   = 1'b1;
    div_sel  = 2'(sel);
    div_data = CNT_W'(data);
    step();
    div_wr   = 1'b0;
  endtask

  // Step until tick[ch] is seen. On timeout, n comes back as budget+1.
  task automatic run_until_tick(input int ch, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n <= budget);
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    en     = '0;
    div_wr = 1'b0;
    sync   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++;
    if (tick !== 4'b0000 || tclk !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_state tick/tclk got %b/%b want 0000/0000", tick, tclk);
    end
  endtask

  task automatic test_default_period();
    int n;
    en = 4'b0001;
    run_until_tick(0, 400, n);
    n_total++;
    if (n != 325) begin
      n_bad++;
      $display("FAIL first_tick_latency got %0d want 325", n);
    end
    n_total++;
    if (tclk[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL tclk0_after_first_tick got %b want 1", tclk[0]);
    end
    run_until_tick(0, 400, n);
    n_total++;
    if (n != 325) begin
      n_bad++;
      $display("FAIL tick_period got %0d want 325", n);
    end
    n_total++;
    if (tclk !== 4'b0000) begin
      n_bad++;
      $display("FAIL tclk_after_two_ticks got %b want 0000", tclk);
    end
  endtask

  task automatic test_div_one();
    logic prev;
    en = 4'b0101;
    write_div(2, 1);
    n_total++;
    if (tick[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL div1_write_edge_tick got %b want 0", tick[2]);
    end
    prev = tclk[2];
    for (int k = 0; k < 8; k++) begin
      step();
      n_total++;
      if (tick[2] !== 1'b1 || tclk[2] !== ~prev) begin
        n_bad++;
        $display("FAIL div1_cycle%0d tick2/tclk2 got %b/%b want 1/%b",
                 k, tick[2], tclk[2], ~prev);
      end
      prev = tclk[2];
    end
    write_div(2, 0);
    prev = tclk[2];
    for (int k = 0; k < 5; k++) begin
      step();
      n_total++;
      if (tick[2] !== 1'b0 || tclk[2] !== prev) begin
        n_bad++;
        $display("FAIL div0_stall%0d tick2/tclk2 got %b/%b want 0/%b",
                 k, tick[2], tclk[2], prev);
      end
    end
  endtask

  task automatic test_write_terminal();
    int n;
    write_div(1, 10);
    en = en | 4'b0010;
    // Nine enabled edges take cnt from 0 to 9, the terminal count for D=10.
    for (int k = 0; k < 9; k++) step();
    write_div(1, 10);
    n_total++;
    if (tick[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL write_at_terminal_tick got %b want 0", tick[1]);
    end
    run_until_tick(1, 40, n);
    n_total++;
    if (n != 10) begin
      n_bad++;
      $display("FAIL tick_after_write got %0d want 10", n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    en = en | 4'b1000;
    write_div(3, 3);
    write_div(3, 5);
    run_until_tick(3, 40, n);
    n_total++;
    if (n != 5) begin
      n_bad++;
      $display("FAIL back_to_back_write_period got %0d want 5", n);
    end
  endtask

  task automatic test_disable();
    int n;
    apply_reset();
    en = 4'b0001;
    run_until_tick(0, 400, n);
    n_total++;
    if (n != 325 || tclk[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL disable_setup n/tclk0 got %0d/%b want 325/1", n, tclk[0]);
    end
    for (int k = 0; k < 100; k++) step();
    en = 4'b0000;
    for (int k = 0; k < 20; k++) step();
    n_total++;
    if (tick[0] !== 1'b0 || tclk[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL disabled_hold tick0/tclk0 got %b/%b want 0/1", tick[0], tclk[0]);
    end
    en = 4'b0001;
    run_until_tick(0, 400, n);
    n_total++;
    if (n != 325) begin
      n_bad++;
      $display("FAIL reenable_period got %0d want 325", n);
    end
  endtask

  task automatic test_async_reset();
    int n;
    write_div(1, 10);
    write_div(2, 1);
    en = 4'b1111;
    for (int k = 0; k < 50; k++) step();
    n_total++;
    if (tick[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_tick2 got %b want 1", tick[2]);
    end
    // Assert reset between clock edges, then check before any rising edge.
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (tick !== 4'b0000 || tclk !== 4'b0000) begin
      n_bad++;
      $display("FAIL async_reset_outputs tick/tclk got %b/%b want 0000/0000", tick, tclk);
    end
    en = 4'b0010;
    step();
    rst_n = 1'b1;
    run_until_tick(1, 400, n);
    n_total++;
    if (n != 325) begin
      n_bad++;
      $display("FAIL divisor_after_reset got %0d want 325", n);
    end
  endtask

`ifdef CLKDIV_PHASE_SYNC_EN
  task automatic test_sync();
    int n;
    apply_reset();
    write_div(0, 7);
    write_div(3, 7);
    en = 4'b0001;
    for (int k = 0; k < 3; k++) step();
    en = 4'b1001;
    for (int k = 0; k < 20; k++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    n_total++;
    if (tclk[0] !== 1'b0 || tclk[3] !== 1'b0 || tick !== 4'b0000) begin
      n_bad++;
      $display("FAIL sync_clear tick/tclk got %b/%b want 0000/0xx0", tick, tclk);
    end
    run_until_tick(0, 20, n);
    n_total++;
    if (n != 7 || tick[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL sync_aligned n/tick3 got %0d/%b want 7/1", n, tick[3]);
    end
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    en       = '0;
    div_wr   = 1'b0;
    div_sel  = '0;
    div_data = '0;
    sync     = 1'b0;
    model_reset();
    test_reset();
    test_default_period();
    test_div_one();
    test_write_terminal();
    test_back_to_back();
    test_disable();
    test_async_reset();
`ifdef CLKDIV_PHASE_SYNC_EN
    test_sync();
`endif
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
